// File: rtl/dbus_pkg.sv
// Data-bus request/response bundles shared between the
// data-memory stage and its responders.
package dbus_pkg;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

endpackage

// File: rtl/dbus_mem_responder.sv
// Slow data-bus memory: one request at a time, fixed latency,
// byte-strobe writes, full aligned 64-bit words returned.
module dbus_mem_responder
    import dbus_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter logic [63:0] BASE_ADDR   = 64'h8000_0000
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output logic       err,
    output logic       busy
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state_q;
    state_t state_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    logic [63:0] mem [DEPTH_WORDS];

    logic [60:0]   woff;
    logic          mis;
    logic          bad_c;
    logic [AW-1:0] idx_c;
    logic          accept;
    logic          enter_resp;
    logic [AW-1:0] rd_idx;
    logic          rd_bad;

    logic [AW-1:0] idx_q;
    logic          bad_q;
    logic [7:0]    strobe_q;
    logic [63:0]   wdata_q;
    logic [63:0]   rdata_q;
    logic          err_q;

    // BASE_ADDR is word aligned, so the word offset needs no borrow
    // from the low address bits; wraps below BASE_ADDR.
    assign woff  = dreq.addr[63:3] - BASE_ADDR[63:3];
    assign idx_c = woff[AW-1:0];
    assign bad_c = mis | (|woff[60:AW]);

    // Natural alignment check for the requested access size
    always_comb begin
        mis = 1'b0;
        unique case (dreq.size)
            MSIZE1: mis = 1'b0;
            MSIZE2: mis = dreq.addr[0];
            MSIZE4: mis = |dreq.addr[1:0];
            MSIZE8: mis = |dreq.addr[2:0];
        endcase
    end

    assign accept     = (state_q == IDLE) && dreq.valid;
    assign enter_resp = (state_d == RESP) && (state_q != RESP);

    // At LATENCY=1 the response is read on the accept edge itself
    assign rd_idx = (state_q == IDLE) ? idx_c : idx_q;
    assign rd_bad = (state_q == IDLE) ? bad_c : bad_q;

    // State and latency counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (dreq.valid) begin
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = (LATENCY > 1) ? WAIT : RESP;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latch and registered response word / error flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q    <= '0;
            bad_q    <= 1'b0;
            strobe_q <= 8'd0;
            wdata_q  <= 64'd0;
            rdata_q  <= 64'd0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                idx_q    <= idx_c;
                bad_q    <= bad_c;
                strobe_q <= dreq.strobe;
                wdata_q  <= dreq.data;
            end
            if (enter_resp) begin
                rdata_q <= rd_bad ? 64'd0 : mem[rd_idx];
                err_q   <= rd_bad;
            end else begin
                err_q   <= 1'b0;
            end
        end
    end

    // Byte-lane write commits only on the edge leaving RESP
    always_ff @(posedge clk) begin
        if (state_q == RESP && !bad_q) begin
            for (int i = 0; i < 8; i++) begin
                if (strobe_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign dresp.addr_ok = accept;
    assign dresp.data_ok = (state_q == RESP);
    assign dresp.data    = rdata_q;
    assign err           = err_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_dbus_mem_responder.sv
// Scoreboard bench for dbus_mem_responder at LATENCY=2 and
// LATENCY=1, directed vectors with hand-computed words.
module tb_dbus_mem_responder;
    import dbus_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    dbus_req_t  dreq0;
    dbus_req_t  dreq1;
    dbus_resp_t resp0;
    dbus_resp_t resp1;
    logic       err0;
    logic       err1;
    logic       busy0;
    logic       busy1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [63:0] data;
        logic        chk;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    dbus_mem_responder #(
        .DEPTH_WORDS(1024),
        .LATENCY(2),
        .BASE_ADDR(64'h8000_0000)
    ) u_dut (
        .clk(clk),
        .reset(reset),
        .dreq(dreq0),
        .dresp(resp0),
        .err(err0),
        .busy(busy0)
    );

    dbus_mem_responder #(
        .DEPTH_WORDS(1024),
        .LATENCY(1),
        .BASE_ADDR(64'h8000_0000)
    ) u_dut1 (
        .clk(clk),
        .reset(reset),
        .dreq(dreq1),
        .dresp(resp1),
        .err(err1),
        .busy(busy1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic mon(input int d, input dbus_resp_t r,
                       input logic e, input logic b);
        exp_t x;
        int   qs;
        qs = (d == 0) ? q0.size() : q1.size();
        if (qs == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_data_ok dut%0d: got data_ok=1, want 0", d);
        end else begin
            if (d == 0) x = q0.pop_front();
            else        x = q1.pop_front();
            check($sformatf("latency dut%0d", d), 64'(cyc), 64'(x.cyc));
            check($sformatf("err dut%0d", d), 64'(e), 64'(x.err));
            check($sformatf("busy_resp dut%0d", d), 64'(b), 64'd1);
            if (x.chk) begin
                check($sformatf("data dut%0d", d), r.data, x.data);
            end
        end
    endtask

    // Monitor: pop and compare whenever a response is presented
    always @(negedge clk) begin
        if (resp0.data_ok === 1'b1) mon(0, resp0, err0, busy0);
        if (resp1.data_ok === 1'b1) mon(1, resp1, err1, busy1);
    end

    task automatic issue(input int d, input logic [63:0] a,
                         input msize_t sz, input logic [7:0] st,
                         input logic [63:0] wd, input logic cd,
                         input logic [63:0] ed, input logic ee,
                         input bit push, output int acc);
        int   n;
        exp_t x;
        logic ao;
        logic bz;
        n = 0;
        @(negedge clk);
        while (((d == 0) ? busy0 : busy1) === 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (d == 0) dreq0 = '{1'b1, a, sz, st, wd};
        else        dreq1 = '{1'b1, a, sz, st, wd};
        #1;
        ao = (d == 0) ? resp0.addr_ok : resp1.addr_ok;
        check($sformatf("addr_ok dut%0d a=%h", d, a), 64'(ao), 64'd1);
        acc = cyc;
        x = '{ed, cd, ee, cyc + ((d == 0) ? 2 : 1)};
        if (push) begin
            if (d == 0) q0.push_back(x);
            else        q1.push_back(x);
        end
        @(posedge clk);
        #1;
        if (d == 0) dreq0.valid = 1'b0;
        else        dreq1.valid = 1'b0;
        bz = (d == 0) ? busy0 : busy1;
        check($sformatf("busy_accept dut%0d", d), 64'(bz), 64'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() + q1.size()) != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(q0.size() + q1.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int a1;
        int a2;
        dreq0 = '0;
        dreq1 = '0;

        #3 reset = 1'b1;
        #1;
        check("reset_resp0", 64'(resp0), 64'd0);
        check("reset_err_busy0", 64'({err0, busy0}), 64'd0);
        check("reset_resp1", 64'(resp1), 64'd0);
        check("reset_err_busy1", 64'({err1, busy1}), 64'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_ok", 64'({resp0.addr_ok, resp0.data_ok}), 64'd0);
        end

        // sd / ld round trip, pre-write data unknown on first write
        issue(0, 64'h8000_0010, MSIZE8, 8'hFF, 64'h1122334455667788,
              1'b0, 64'd0, 1'b0, 1'b1, a0);
        issue(0, 64'h8000_0010, MSIZE8, 8'h00, 64'd0,
              1'b1, 64'h1122334455667788, 1'b0, 1'b1, a0);
        // sb lane 3, returns pre-write word
        issue(0, 64'h8000_0013, MSIZE1, 8'h08, 64'h00000000AA000000,
              1'b1, 64'h1122334455667788, 1'b0, 1'b1, a0);
        issue(0, 64'h8000_0010, MSIZE8, 8'h00, 64'd0,
              1'b1, 64'h11223344AA667788, 1'b0, 1'b1, a0);
        // misaligned sw and sh
        issue(0, 64'h8000_0012, MSIZE4, 8'hF0, 64'hFFFFFFFFFFFFFFFF,
              1'b1, 64'd0, 1'b1, 1'b1, a0);
        issue(0, 64'h8000_0011, MSIZE2, 8'h06, 64'hFFFFFFFFFFFFFFFF,
              1'b1, 64'd0, 1'b1, 1'b1, a0);
        // aligned lh read, full word returned
        issue(0, 64'h8000_0016, MSIZE2, 8'h00, 64'd0,
              1'b1, 64'h11223344AA667788, 1'b0, 1'b1, a0);
        // out of range high and below base
        issue(0, 64'h8000_2000, MSIZE8, 8'h00, 64'd0,
              1'b1, 64'd0, 1'b1, 1'b1, a0);
        issue(0, 64'h7FFF_FFF8, MSIZE8, 8'h00, 64'd0,
              1'b1, 64'd0, 1'b1, 1'b1, a0);
        // last word in range
        issue(0, 64'h8000_1FF8, MSIZE8, 8'hFF, 64'hCAFEF00D12345678,
              1'b0, 64'd0, 1'b0, 1'b1, a0);
        issue(0, 64'h8000_1FF8, MSIZE8, 8'h00, 64'd0,
              1'b1, 64'hCAFEF00D12345678, 1'b0, 1'b1, a0);
        drain();

        // reset in WAIT drops the pending write
        issue(0, 64'h8000_0010, MSIZE8, 8'hFF, 64'h000000000000DEAD,
              1'b0, 64'd0, 1'b0, 1'b0, a0);
        #1 reset = 1'b1;
        #1;
        check("midreset_busy", 64'(busy0), 64'd0);
        check("midreset_resp", 64'({resp0.addr_ok, resp0.data_ok}), 64'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) @(negedge clk);
        issue(0, 64'h8000_0010, MSIZE8, 8'h00, 64'd0,
              1'b1, 64'h11223344AA667788, 1'b0, 1'b1, a0);

        // LATENCY=1 back-to-back
        issue(1, 64'h8000_0008, MSIZE8, 8'hFF, 64'hA5A5000012345678,
              1'b0, 64'd0, 1'b0, 1'b1, a0);
        issue(1, 64'h8000_0008, MSIZE8, 8'h00, 64'd0,
              1'b1, 64'hA5A5000012345678, 1'b0, 1'b1, a1);
        issue(1, 64'h7FFF_FFF8, MSIZE8, 8'h00, 64'd0,
              1'b1, 64'd0, 1'b1, 1'b1, a2);
        check("b2b_gap1", 64'(a1 - a0), 64'd2);
        check("b2b_gap2", 64'(a2 - a1), 64'd2);
        drain();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/dbus_mem_responder.md
Name: dbus_mem_responder

Overview:
- Responder end of the data bus: accepts one `dbus_req_t` at a time from the data-memory stage and answers with `dbus_resp_t` after a fixed, programmable latency.
- Backs requests with an internal 64-bit-word RAM.
- Models a slow memory for pipeline bring-up and stall testing.
- Performs byte-strobe writes, returns full aligned 64-bit words (the initiator shifts and sign-extends), and flags misaligned or out-of-range accesses.

Parameters:
- `DEPTH_WORDS`, 1024: number of 64-bit words in the RAM; power of two.
- `LATENCY`, 2: cycles from the accept cycle to the `data_ok` cycle; legal range 1..15.
- `BASE_ADDR`, 64'h8000_0000: byte address mapped to word 0.

Ports:
- `clk`, input, 1: clock.
- `reset`, input, 1: asynchronous, active-high reset.
- `dreq`, input, `dbus_req_t`: valid, addr[63:0], size (`msize_t`), strobe[7:0], data[63:0].
- `dresp`, output, `dbus_resp_t`: addr_ok, data_ok, data[63:0].
- `err`, output, 1: pulses with `data_ok` when the completed access was misaligned or out of range.
- `busy`, output, 1: high whenever state != IDLE.

Behaviour:
- **Reset values:** asserting `reset` forces state=IDLE, counter=0, `dresp.addr_ok`=0, `dresp.data_ok`=0, `dresp.data`=0, `err`=0, `busy`=0. Reset does not clear RAM contents. Reset mid-transaction drops the transaction; a pending write is never committed.
- **State machine:** IDLE -> WAIT -> RESP -> IDLE.
- **IDLE:**
  - `addr_ok` = `dreq.valid`, combinational, same cycle.
  - On the edge with `dreq.valid`=1, latch addr, size, strobe and data.
  - Compute `idx` = (addr - BASE_ADDR) >> 3.
  - Compute `bad` = misaligned OR `idx` >= DEPTH_WORDS. Misaligned means addr[0]!=0 for MSIZE2, addr[1:0]!=0 for MSIZE4, or addr[2:0]!=0 for MSIZE8; MSIZE1 is never misaligned.
  - Load counter = LATENCY-1. Go to WAIT if LATENCY>1, else to RESP.
- **WAIT:**
  - `addr_ok`=0; `dreq` is ignored.
  - Decrement the counter; when it reads 1, the next state is RESP.
  - On the edge entering RESP, register `dresp.data` = `bad` ? 0 : mem[`idx`] (pre-write contents) and `err` = `bad`.
- **RESP:**
  - `data_ok`=1 for exactly one cycle. `err` is valid in this cycle only.
  - On the edge leaving RESP, if strobe!=0 and !`bad`, each byte lane i with strobe[i]=1 writes mem[`idx`][8i+7:8i] = latched data[8i+7:8i]. Other lanes are unchanged.
  - Next state is IDLE.
  - `dresp.data` holds its last value outside RESP; the initiator must sample only on `data_ok`.
- **Request kinds:** strobe==0 is a read. Any nonzero strobe is a write; a write still returns the pre-write word in `data`.
- **Latency:** accept cycle = cycle 0; `data_ok` asserts in cycle LATENCY. Minimum turnaround to the next accept is LATENCY+1 cycles after the previous accept.
- **Back-to-back requests:** a request presented in the cycle after RESP is accepted immediately (IDLE). The initiator is required to drop or change `valid` after observing `data_ok`. A `valid` still high in that cycle is treated as a new request.
- **Strobe/size consistency:** the strobe is applied exactly as given and is not checked against size.
- **Address arithmetic:** the subtraction wraps at 64 bits, so addresses below BASE_ADDR yield a huge `idx` and are flagged `bad`.

Test Plan:
- **Reset:** assert `reset` mid-cycle with no clock -> all outputs 0 immediately. Deassert and hold `valid`=0 for 10 cycles -> `addr_ok`=`data_ok`=0.
- **sd then ld at LATENCY=2:** sd addr=0x8000_0010, strobe=0xFF, data=0x1122334455667788. Then ld same addr, strobe=0 -> `data_ok` exactly 2 cycles after each accept; second `data`=0x1122334455667788; `err`=0.
- **sb lane write:** sb addr=0x8000_0013, strobe=0x08, data=0x00000000AA000000 over word 0x1122334455667788 -> following ld returns 0x11223344AA667788.
- **Misaligned sw:** sw addr=0x8000_0012, MSIZE4, strobe=0xF0 -> `err`=1 with `data_ok`, `data`=0, memory word unchanged on re-read.
- **Out of range:** ld addr=0x8000_0000 + 8*DEPTH_WORDS, and ld addr=0x7FFF_FFF8 -> `err`=1, `data`=0, `busy` high from accept to end of RESP.
- **Reset mid-WAIT and LATENCY=1:** issue sd data=0xDEAD, assert reset in WAIT -> no `data_ok`, and a later ld returns the old word. Separately at LATENCY=1 -> `data_ok` in the cycle after accept and back-to-back requests accepted every 2 cycles.
